control_sequencer: RTL and testbench

//  Multicycle control unit placed directly upstream of the 8x8-bit register/ALU datapath.

---
 rtl/control_sequencer_if.sv | 47 ++++
 rtl/control_sequencer.sv | 115 +++++++++++
 tb/tb_control_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// ---------------------------------------------------------------------------
// control_sequencer_if
//   Bundles the sequencer's instruction-ROM port, datapath control word and
//   datapath flag inputs.
//   master : the sequencer (drives Iaddr and the control word, reads Instr/flags)
//   slave  : ROM + datapath side (drives run, Instr, Z, N)
//   Signals:
//     run     1     allow a new fetch
//     Instr   20    instruction word at Iaddr (combinational ROM read)
//     Iaddr   PC_W  instruction address (= PC)
//     Z, N    1     datapath zero / negative flags
//     RW      1     register write enable
//     DA/AA/BA 3    destination / A / B register selects
//     MB      1     B operand from Con_in
//     FS      4     ALU function select
//     MD      1     write-back from Datain
//     Con_in  8     immediate constant
//     halted  1     sequencer parked in HALT
// ---------------------------------------------------------------------------
interface control_sequencer_if #(
   parameter int PC_W = 8
);
   logic            run;
   logic [19:0]     Instr;
   logic [PC_W-1:0] Iaddr;
   logic            Z;
   logic            N;
   logic            RW;
   logic [2:0]      DA;
   logic [2:0]      AA;
   logic [2:0]      BA;
   logic            MB;
   logic [3:0]      FS;
   logic            MD;
   logic [7:0]      Con_in;
   logic            halted;

   modport master (
      input  run, Instr, Z, N,
      output Iaddr, RW, DA, AA, BA, MB, FS, MD, Con_in, halted
   );

   modport slave (
      output run, Instr, Z, N,
      input  Iaddr, RW, DA, AA, BA, MB, FS, MD, Con_in, halted
   );
endinterface

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//   Multicycle control unit in front of the 8x8 register/ALU datapath.
//   Fetches 20-bit instructions, sequences FETCH/OPRD/EXEC/WB for ALU ops,
//   FETCH/WB for loads, FETCH/BR for branches, and parks in HALT.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    control_sequencer_if.master (ROM port, control word, flags)
// ---------------------------------------------------------------------------
module control_sequencer #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   control_sequencer_if.master bus
);

   localparam logic [2:0] S_FETCH = 3'd0;
   localparam logic [2:0] S_OPRD  = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_WB    = 3'd3;
   localparam logic [2:0] S_BR    = 3'd4;
   localparam logic [2:0] S_HALT  = 3'd5;

   localparam logic [1:0] C_ALU  = 2'b00;
   localparam logic [1:0] C_ALUI = 2'b01;
   localparam logic [1:0] C_LOAD = 2'b10;

   logic [2:0]      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [19:0]     ir_q, ir_d;
   logic            zf_q, zf_d;
   logic            nf_q, nf_d;

   logic [1:0]      cls;
   logic [3:0]      cond;

   assign cls  = ir_q[19:18];
   assign cond = ir_q[17:14];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      zf_d    = zf_q;
      nf_d    = nf_q;
      case (state_q)
         S_FETCH: begin
            if (bus.run) begin
               ir_d = bus.Instr;
               pc_d = pc_q + PC_W'(1);
               case (bus.Instr[19:18])
                  C_ALU, C_ALUI: state_d = S_OPRD;
                  C_LOAD:        state_d = S_WB;
                  default:       state_d = S_BR;
               endcase
            end
         end
         S_OPRD: state_d = S_EXEC;
         S_EXEC: state_d = S_WB;
         S_WB: begin
            // ALU results update the flags; loads bypass the ALU and must not
            if (!cls[1]) begin
               zf_d = bus.Z;
               nf_d = bus.N;
            end
            state_d = S_FETCH;
         end
         S_BR: begin
            state_d = S_FETCH;
            case (cond)
               4'b0000: pc_d = PC_W'(ir_q[7:0]);
               4'b0001: if (zf_q) pc_d = PC_W'(ir_q[7:0]);
               4'b0010: if (nf_q) pc_d = PC_W'(ir_q[7:0]);
               4'b0011: state_d = S_HALT;
               default: ;
            endcase
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         zf_q    <= 1'b0;
         nf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         zf_q    <= zf_d;
         nf_q    <= nf_d;
      end
   end

   // Field outputs come straight from IR so they hold steady for the whole
   // instruction; RW/halted are pure state decodes so reset kills them at once.
   assign bus.Iaddr  = pc_q;
   assign bus.RW     = (state_q == S_WB);
   assign bus.halted = (state_q == S_HALT);
   assign bus.DA     = ir_q[13:11];
   assign bus.AA     = ir_q[10:8];
   assign bus.BA     = ir_q[7:5];
   assign bus.FS     = ir_q[17:14];
   assign bus.Con_in = ir_q[7:0];
   assign bus.MB     = (cls == C_ALUI);
   assign bus.MD     = (cls == C_LOAD);

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   control_sequencer_if #(.PC_W(8)) bus ();

   control_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [19:0] rom [0:255];
   assign bus.Instr = rom[bus.Iaddr];
   // Stand-in for the datapath flags: chosen per address so that specific
   // ALU write-backs produce known Z/N values.
   assign bus.Z = (bus.Iaddr == 8'h06);
   assign bus.N = (bus.Iaddr == 8'h02) || (bus.Iaddr == 8'h41);

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [19:0] ins(input logic [1:0] c, input logic [3:0] f,
                                       input logic [2:0] dr, input logic [2:0] sa,
                                       input logic [7:0] lo);
      return {c, f, dr, sa, lo};
   endfunction

   // ---------------- instruction-level model ----------------
   // Tracks each instruction as "cycles since fetch" against its total latency
   // (ALU 4, LOAD 2, branch 2); effects land on the last cycle's edge.
   logic [7:0]  m_pc;
   logic [19:0] m_ir;
   logic        m_zf, m_nf, m_busy, m_halt;
   int          m_ph;

   function automatic int ilen(input logic [1:0] c);
      return (c[1] == 1'b0) ? 4 : 2;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc <= 8'h00; m_ir <= '0; m_zf <= 1'b0; m_nf <= 1'b0;
         m_busy <= 1'b0; m_halt <= 1'b0; m_ph <= 0;
      end else if (m_halt) begin
         m_ph <= 0;
      end else if (!m_busy) begin
         if (bus.run) begin
            m_ir <= rom[m_pc]; m_pc <= m_pc + 8'd1; m_busy <= 1'b1; m_ph <= 1;
         end
      end else if (m_ph == ilen(m_ir[19:18]) - 1) begin
         m_busy <= 1'b0; m_ph <= 0;
         if (m_ir[19:18] == 2'b00 || m_ir[19:18] == 2'b01) begin
            m_zf <= bus.Z; m_nf <= bus.N;
         end else if (m_ir[19:18] == 2'b11) begin
            if (m_ir[17:14] == 4'd0) m_pc <= m_ir[7:0];
            else if (m_ir[17:14] == 4'd1 && m_zf) m_pc <= m_ir[7:0];
            else if (m_ir[17:14] == 4'd2 && m_nf) m_pc <= m_ir[7:0];
            else if (m_ir[17:14] == 4'd3) m_halt <= 1'b1;
         end
      end else begin
         m_ph <= m_ph + 1;
      end
   end

   logic [32:0] exp_v, act_v;
   logic        exp_rw;
   always_comb begin
      exp_rw = m_busy && (m_ir[19:18] != 2'b11) && (m_ph == ilen(m_ir[19:18]) - 1);
      exp_v  = {m_pc, exp_rw, m_halt, m_ir[13:11], m_ir[10:8], m_ir[7:5],
                (m_ir[19:18] == 2'b01), m_ir[17:14], (m_ir[19:18] == 2'b10), m_ir[7:0]};
      act_v  = {bus.Iaddr, bus.RW, bus.halted, bus.DA, bus.AA, bus.BA,
                bus.MB, bus.FS, bus.MD, bus.Con_in};
   end

   always @(posedge clk) begin
      #1;
      if (chk_en) chk("cycle_outputs", 64'(act_v), 64'(exp_v));
   end

   // ---------------- directed stimulus + literal expectations ----------------
   task automatic wait_addr(input logic [7:0] a);
      bit hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         if (bus.Iaddr == a) hit = 1'b1;
      end
      chk($sformatf("reach_addr_%0h", a), 64'(hit), 64'd1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = '0;
      rom[8'h00] = ins(2'b00, 4'd2, 3'd1, 3'd2, 8'h60); // ADD R1=R2+R3
      rom[8'h01] = ins(2'b01, 4'd2, 3'd4, 3'd4, 8'h05); // ADDI R4+=5 (N=1)
      rom[8'h02] = ins(2'b10, 4'd0, 3'd6, 3'd0, 8'h00); // LOAD R6
      rom[8'h03] = ins(2'b11, 4'd2, 3'd0, 3'd0, 8'h05); // BN 0x05 (nf from ADDI)
      rom[8'h04] = ins(2'b11, 4'd3, 3'd0, 3'd0, 8'h00); // HALT (skipped)
      rom[8'h05] = ins(2'b00, 4'd5, 3'd7, 3'd1, 8'h40); // SUB (Z=1)
      rom[8'h06] = ins(2'b11, 4'd1, 3'd0, 3'd0, 8'h40); // BZ 0x40 taken
      rom[8'h40] = ins(2'b00, 4'd5, 3'd3, 3'd3, 8'h80); // SUB (Z=0,N=1)
      rom[8'h41] = ins(2'b11, 4'd1, 3'd0, 3'd0, 8'h80); // BZ not taken
      rom[8'h42] = ins(2'b11, 4'd2, 3'd0, 3'd0, 8'h60); // BN 0x60 taken
      rom[8'h60] = ins(2'b11, 4'd0, 3'd0, 3'd0, 8'hFE); // B 0xFE
      rom[8'hFE] = ins(2'b11, 4'd7, 3'd0, 3'd0, 8'h10); // NOP branch
      rom[8'hFF] = ins(2'b11, 4'd3, 3'd0, 3'd0, 8'h00); // HALT, PC wraps

      rst_n = 1'b0; bus.run = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_iaddr",  64'(bus.Iaddr),  64'h0);
      chk("rst_rw",     64'(bus.RW),     64'h0);
      chk("rst_halted", 64'(bus.halted), 64'h0);
      chk("rst_fields", 64'({bus.DA, bus.AA, bus.BA, bus.FS, bus.Con_in, bus.MB, bus.MD}), 64'h0);
      rst_n = 1'b1; chk_en = 1'b1;

      repeat (3) begin
         @(negedge clk);
         chk("stall_iaddr", 64'(bus.Iaddr), 64'h0);
         chk("stall_rw",    64'(bus.RW),    64'h0);
      end
      bus.run = 1'b1;

      @(negedge clk); // ADD OPRD
      chk("add_oprd_aa", 64'(bus.AA), 64'd2);
      chk("add_oprd_ba", 64'(bus.BA), 64'd3);
      chk("add_oprd_mb", 64'(bus.MB), 64'd0);
      chk("add_iaddr",   64'(bus.Iaddr), 64'd1);
      @(negedge clk); // EXEC
      chk("add_exec_fs", 64'(bus.FS), 64'h2);
      chk("add_exec_rw", 64'(bus.RW), 64'd0);
      @(negedge clk); // WB
      chk("add_wb_rw", 64'(bus.RW), 64'd1);
      chk("add_wb_da", 64'(bus.DA), 64'd1);
      chk("add_wb_md", 64'(bus.MD), 64'd0);
      @(negedge clk); // FETCH
      chk("fetch1_iaddr", 64'(bus.Iaddr), 64'd1);
      chk("fetch1_rw",    64'(bus.RW),    64'd0);

      repeat (2) begin
         @(negedge clk); // ADDI OPRD, EXEC
         chk("addi_mb",  64'(bus.MB),     64'd1);
         chk("addi_con", 64'(bus.Con_in), 64'h05);
         chk("addi_rw0", 64'(bus.RW),     64'd0);
      end
      @(negedge clk); // WB
      chk("addi_wb_rw",  64'(bus.RW),     64'd1);
      chk("addi_wb_con", 64'(bus.Con_in), 64'h05);
      @(negedge clk);
      chk("fetch2_iaddr", 64'(bus.Iaddr), 64'd2);

      @(negedge clk); // LOAD WB, one cycle after fetch
      chk("load_wb_rw", 64'(bus.RW), 64'd1);
      chk("load_wb_da", 64'(bus.DA), 64'd6);
      chk("load_wb_md", 64'(bus.MD), 64'd1);
      @(negedge clk);
      chk("fetch3_iaddr", 64'(bus.Iaddr), 64'd3);
      chk("fetch3_rw",    64'(bus.RW),    64'd0);

      wait_addr(8'h05);
      wait_addr(8'h40);
      wait_addr(8'h42);
      wait_addr(8'h60);
      wait_addr(8'hFE);
      begin
         bit h = 1'b0;
         for (int i = 0; i < 100 && !h; i++) begin
            @(negedge clk);
            h = bus.halted;
         end
         chk("reach_halt", 64'(h), 64'd1);
      end
      chk("wrap_iaddr", 64'(bus.Iaddr), 64'h00);

      repeat (6) begin
         bus.run = ~bus.run;
         @(negedge clk);
         chk("halt_hold", 64'(bus.halted), 64'd1);
         chk("halt_rw",   64'(bus.RW),     64'd0);
      end

      rst_n = 1'b0; #1;
      chk("rst_from_halt", 64'(bus.halted), 64'd0);
      @(negedge clk); rst_n = 1'b1; bus.run = 1'b1;
      @(negedge clk); // ADD OPRD
      chk("refetch_iaddr", 64'(bus.Iaddr), 64'd1);
      @(negedge clk); // ADD EXEC
      rst_n = 1'b0; #1;
      chk("exec_rst_rw",    64'(bus.RW),    64'd0);
      chk("exec_rst_iaddr", 64'(bus.Iaddr), 64'd0);
      chk("exec_rst_aa",    64'(bus.AA),    64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); // re-fetched from RESET_PC
      chk("post_rst_iaddr", 64'(bus.Iaddr), 64'd1);
      chk("post_rst_aa",    64'(bus.AA),    64'd2);
      repeat (2) @(negedge clk); // WB
      chk("wb_before_rst", 64'(bus.RW), 64'd1);
      rst_n = 1'b0; #1;
      chk("wb_rst_rw", 64'(bus.RW), 64'd0);
      @(negedge clk); rst_n = 1'b1; bus.run = 1'b0;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
